tap_chain_param: RTL and testbench

TAP_CHAIN_PARAM -- requirements
Module: tap_chain_param

---
 rtl/tap_chain_pkg.sv | 23 ++
 rtl/tap_chain_stage.sv | 26 ++
 rtl/tap_chain_param.sv | 139 +++++++++++++
 tb/tb_tap_chain_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_chain_pkg.sv
// Shared defaults, sample type and derived widths for the tap chain.
// The running-sum output is built only when TAP_CHAIN_SUM_EN is defined.
package tap_chain_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DEPTH_DEF  = 32;
    localparam int STRIDE_DEF = 1;

    localparam int FILL_W_DEF = $clog2(DEPTH_DEF + 1);
    localparam int SUM_W_DEF  = WIDTH_DEF + $clog2(DEPTH_DEF);

    typedef logic signed [WIDTH_DEF-1:0] sample_t;

    // The sum width leaves exactly enough headroom for DEPTH full-scale samples.
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int sum_w(input int width, input int depth);
        return width + $clog2(depth);
    endfunction

endpackage

// File: rtl/tap_chain_stage.sv
// One tap of the chain: a WIDTH-bit register with load enable and synchronous flush.
module tap_chain_stage
    import tap_chain_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Flush wins over a simultaneous load so a dropped sample never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tap_chain_param.sv
// Parameterised sample shift chain with fill tracking and stride-spaced window pulses.
// Define TAP_CHAIN_SUM_EN to build the registered sum of all taps (sum_o/sum_valid).
module tap_chain_param
    import tap_chain_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic        [WIDTH-1:0]              in_data,
    input  logic                                 flush,
    output logic        [DEPTH*WIDTH-1:0]        taps_o,
    output logic        [$clog2(DEPTH+1)-1:0]    fill_cnt,
    output logic                                 full,
    output logic                                 win_valid,
    output logic signed [WIDTH+$clog2(DEPTH)-1:0] sum_o,
    output logic                                 sum_valid
);

    localparam int FILL_W = fill_w(DEPTH);
    localparam int SUM_W  = sum_w(WIDTH, DEPTH);
    localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [FILL_W-1:0] DEPTH_F     = FILL_W'(DEPTH);
    localparam logic [STR_W-1:0]  STRIDE_LAST = STR_W'(STRIDE - 1);

    // Input handshake: there is no ready; a sample is taken on every rising edge
    // where in_valid=1 and flush=0, and in_data must be stable for that edge.
    logic accept;
    assign accept = in_valid & ~flush;

    logic signed [WIDTH-1:0] tap_q [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        logic [WIDTH-1:0] stage_d;
        if (k == 0) begin : g_head
            assign stage_d = in_data;
        end else begin : g_body
            assign stage_d = tap_q[k-1];
        end

        tap_chain_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (accept),
            .flush (flush),
            .d     (stage_d),
            .q     (tap_q[k])
        );

        assign taps_o[k*WIDTH +: WIDTH] = tap_q[k];
    end

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;
    logic [STR_W-1:0]  stride_q;
    logic [STR_W-1:0]  stride_next;
    logic              pulse_next;
    logic              win_q;

    // The stride phase restarts on the accept that completes the first window,
    // so that accept itself always produces a pulse.
    always_comb begin
        fill_next   = fill_q;
        stride_next = stride_q;
        pulse_next  = 1'b0;
        if (accept) begin
            if (fill_q != DEPTH_F) begin
                fill_next = fill_q + 1'b1;
                if (fill_q == DEPTH_F - 1'b1) begin
                    stride_next = '0;
                    pulse_next  = 1'b1;
                end
            end else begin
                stride_next = (stride_q == STRIDE_LAST) ? '0 : stride_q + 1'b1;
                pulse_next  = (stride_next == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q   <= '0;
            stride_q <= '0;
            win_q    <= 1'b0;
        end else if (flush) begin
            fill_q   <= '0;
            stride_q <= '0;
            win_q    <= 1'b0;
        end else begin
            fill_q   <= fill_next;
            stride_q <= stride_next;
            win_q    <= pulse_next;
        end
    end

    assign fill_cnt  = fill_q;
    assign full      = (fill_q == DEPTH_F);
    assign win_valid = win_q;

`ifdef TAP_CHAIN_SUM_EN
    logic signed [SUM_W-1:0] tap_sum;
    logic signed [SUM_W-1:0] sum_q;
    logic                    sum_valid_q;

    always_comb begin
        tap_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            tap_sum = tap_sum + SUM_W'(tap_q[k]);
        end
    end

    // Sum trails the taps by one register, so sum_valid is win_valid delayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else if (flush) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_q       <= tap_sum;
            sum_valid_q <= win_q;
        end
    end

    assign sum_o     = sum_q;
    assign sum_valid = sum_valid_q;
`else
    assign sum_o     = '0;
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_tap_chain_param.sv
// Directed bench for tap_chain_param: STRIDE=1 and STRIDE=4 instances share stimulus.
// Expected windows are queued at stimulus time and popped when win_valid rises.
module tb_tap_chain_param;
    import tap_chain_pkg::*;

    localparam int W   = 16;
    localparam int D   = 32;
    localparam int FW  = $clog2(D + 1);
    localparam int SW  = W + $clog2(D);

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            flush;

    logic [D*W-1:0]  taps_o;
    logic [FW-1:0]   fill_cnt;
    logic            full;
    logic            win_valid;
    logic [SW-1:0]   sum_o;
    logic            sum_valid;

    logic [D*W-1:0]  taps4;
    logic [FW-1:0]   fill4;
    logic            full4;
    logic            win4;
    logic [SW-1:0]   sum4;
    logic            sumv4;

    tap_chain_param #(.WIDTH(W), .DEPTH(D), .STRIDE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .taps_o    (taps_o),
        .fill_cnt  (fill_cnt),
        .full      (full),
        .win_valid (win_valid),
        .sum_o     (sum_o),
        .sum_valid (sum_valid)
    );

    tap_chain_param #(.WIDTH(W), .DEPTH(D), .STRIDE(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .taps_o    (taps4),
        .fill_cnt  (fill4),
        .full      (full4),
        .win_valid (win4),
        .sum_o     (sum4),
        .sum_valid (sumv4)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic [D*W-1:0] exp_q[$];

    sample_t     m_taps [D];
    int          m_fill;
    int          m_s4;
    logic        m_win;
    logic        m_win4;
    logic [SW-1:0] m_sum;
    logic        m_sumv;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [D*W-1:0] model_pack();
        logic [D*W-1:0] r;
        for (int k = 0; k < D; k++) r[k*W +: W] = m_taps[k];
        return r;
    endfunction

    function automatic logic [SW-1:0] model_sum();
        longint s = 0;
        for (int k = 0; k < D; k++) s += longint'(m_taps[k]);
        return s[SW-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) m_taps[k] = '0;
        m_fill = 0;
        m_s4   = 0;
        m_win  = 1'b0;
        m_win4 = 1'b0;
        m_sum  = '0;
        m_sumv = 1'b0;
        exp_q.delete();
    endtask

    // driver: one clock with the given inputs, then model update and checks
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic f);
        logic [SW-1:0] nsum;
        logic          nsumv;
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        #1;
        nsum  = f ? '0 : model_sum();
        nsumv = f ? 1'b0 : m_win;
        if (f) begin
            for (int k = 0; k < D; k++) m_taps[k] = '0;
            m_fill = 0;
            m_s4   = 0;
            m_win  = 1'b0;
            m_win4 = 1'b0;
        end else if (v) begin
            for (int k = D - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
            m_taps[0] = d;
            if (m_fill < D) begin
                m_fill++;
                m_win  = (m_fill == D);
                m_win4 = (m_fill == D);
                m_s4   = 0;
            end else begin
                m_s4   = (m_s4 == 3) ? 0 : m_s4 + 1;
                m_win  = 1'b1;
                m_win4 = (m_s4 == 0);
            end
        end else begin
            m_win  = 1'b0;
            m_win4 = 1'b0;
        end
        if (m_win) exp_q.push_back(model_pack());
`ifdef TAP_CHAIN_SUM_EN
        m_sum  = nsum;
        m_sumv = nsumv;
`else
        m_sum  = '0;
        m_sumv = 1'b0;
`endif
        chk("win_valid", win_valid, m_win);
        chk("win_valid_s4", win4, m_win4);
        chk("fill_cnt", fill_cnt, m_fill);
        chk("full", full, m_fill == D);
        chk("taps", taps_o, model_pack());
        chk("sum_o", sum_o, m_sum);
        chk("sum_valid", sum_valid, m_sumv);
        if (win_valid === 1'b1) begin
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("sb_window", taps_o, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [7:0]    pat4;
        logic [SW-1:0] exp_sum;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        model_reset();
        #12;
        chk("rst_taps", taps_o, '0);
        chk("rst_fill", fill_cnt, '0);
        chk("rst_win", win_valid, 1'b0);
        chk("rst_sum", sum_o, '0);
        chk("rst_sumv", sum_valid, 1'b0);
        #10;
        rst_n = 1'b1;

        // fill to 31, then complete the window
        for (int i = 1; i <= 31; i++) cycle(1'b1, W'(i), 1'b0);
        chk("fill31_cnt", fill_cnt, 31);
        chk("fill31_full", full, 1'b0);
        cycle(1'b1, 16'd32, 1'b0);
        chk("full_tap0", taps_o[0 +: W], 16'd32);
        chk("full_tap31", taps_o[31*W +: W], 16'd1);
        chk("full_pulse", win_valid, 1'b1);

        // eight more accepts: stride-4 instance pulses on the 4th and 8th
        pat4 = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, W'($urandom_range(0, 16'hFFFF)), 1'b0);
            pat4[i] = win4;
        end
        chk("stride4_pattern", pat4, 8'b1000_1000);

        // idle cycles interleaved with accepts while full
        cycle(1'b1, W'($urandom_range(0, 16'hFFFF)), 1'b0);
        cycle(1'b0, W'($urandom_range(0, 16'hFFFF)), 1'b0);
        cycle(1'b1, W'($urandom_range(0, 16'hFFFF)), 1'b0);
        cycle(1'b0, W'($urandom_range(0, 16'hFFFF)), 1'b0);

        // flush beats a simultaneous accept
        cycle(1'b1, 16'h7FFF, 1'b1);
        chk("flush_taps", taps_o, '0);
        chk("flush_fill", fill_cnt, '0);
        cycle(1'b0, 16'h0000, 1'b0);
        chk("flush_dropped", taps_o[0 +: W], 16'h0000);

        // most negative samples exercise the sum headroom
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'h8000, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
`ifdef TAP_CHAIN_SUM_EN
        exp_sum = 21'h100000;
        chk("neg_sum", sum_o, exp_sum);
        chk("neg_sumv", sum_valid, 1'b1);
`else
        exp_sum = '0;
        chk("neg_sum", sum_o, exp_sum);
        chk("neg_sumv", sum_valid, 1'b0);
`endif

        // asynchronous reset in the middle of a fill
        cycle(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, W'($urandom_range(1, 16'hFFFF)), 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_taps", taps_o, '0);
        chk("async_fill", fill_cnt, '0);
        chk("async_full", full, 1'b0);
        chk("async_win", win_valid, 1'b0);
        chk("async_sum", sum_o, '0);
        chk("async_sumv", sum_valid, 1'b0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 16'h1234, 1'b0);
        chk("post_rst_fill", fill_cnt, 1);
        chk("post_rst_tap0", taps_o[0 +: W], 16'h1234);

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
